// File: rtl/axi_pkg.sv
// Shared AXI-Lite definitions: master FSM state encoding and response codes.
package axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AR      = 3'd1,
    R       = 3'd2,
    AW_W    = 3'd3,
    WAIT_AW = 3'd4,
    WAIT_W  = 3'd5,
    B       = 3'd6,
    ACK     = 3'd7
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_TIMEOUT = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;

  // States in which the master is waiting on the slave and may time out.
  function automatic logic is_wait_state(state_t s);
    return (s inside {AR, R, AW_W, WAIT_AW, WAIT_W, B});
  endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// Per-phase wait counter; expired is high in the TIMEOUT-th consecutive enabled cycle.
module axil_timeout_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT > 0) begin : g_cnt
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Saturates at LAST so the compare can never be skipped by a wrap.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = en && (cnt_q == LAST);
    end else begin : g_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/axil_master_gen.sv
// Simple request/ready handshake to AXI4-Lite master bridge, one transaction at a time.
module axil_master_gen
  import axi_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 256,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hs_read_i,
  input  logic              hs_write_i,
  input  logic [ADDR_W-1:0] hs_addr_i,
  input  logic [DATA_W-1:0] hs_data_i,
  input  logic [STRB_W-1:0] byte_select_i,
  output logic              hs_ready_o,
  output logic [DATA_W-1:0] hs_data_o,
  output logic              hs_err_o,
  output logic [1:0]        hs_errcode_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ADDR_W-1:0] araddr_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  input  logic              bvalid_i,
  output logic              bready_o,
  input  logic [1:0]        bresp_i
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          code_q, code_d;
  logic                expired;
  logic                cnt_clr;

  // The counter restarts on every state change so each phase gets its own budget.
  assign cnt_clr = (state_d != state_q);

  axil_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (cnt_clr),
    .en      (is_wait_state(state_q)),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (hs_read_i || hs_write_i) begin
          addr_d  = hs_addr_i;
          wdata_d = hs_data_i;
          strb_d  = byte_select_i;
          state_d = hs_read_i ? AR : AW_W;
        end
      end
      AR: begin
        if (arready_i) begin
          state_d = R;
        end else if (expired) begin
          state_d = ACK;
          code_d  = RESP_TIMEOUT;
        end
      end
      R: begin
        if (rvalid_i) begin
          rdata_d = rdata_i;
          code_d  = rresp_i;
          state_d = ACK;
        end else if (expired) begin
          state_d = ACK;
          code_d  = RESP_TIMEOUT;
        end
      end
      AW_W: begin
        // A handshake in the expiry cycle still counts as accepted by the slave.
        if (awready_i && wready_i) begin
          state_d = B;
        end else if (awready_i) begin
          state_d = WAIT_W;
        end else if (wready_i) begin
          state_d = WAIT_AW;
        end else if (expired) begin
          state_d = ACK;
          code_d  = RESP_TIMEOUT;
        end
      end
      WAIT_AW: begin
        if (awready_i) begin
          state_d = B;
        end else if (expired) begin
          state_d = ACK;
          code_d  = RESP_TIMEOUT;
        end
      end
      WAIT_W: begin
        if (wready_i) begin
          state_d = B;
        end else if (expired) begin
          state_d = ACK;
          code_d  = RESP_TIMEOUT;
        end
      end
      B: begin
        if (bvalid_i) begin
          code_d  = bresp_i;
          state_d = ACK;
        end else if (expired) begin
          state_d = ACK;
          code_d  = RESP_TIMEOUT;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      code_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
    end
  end

  // All handshake outputs decode from the registered state, so reset clears them at once.
  assign arvalid_o    = (state_q == AR);
  assign rready_o     = (state_q == R);
  assign awvalid_o    = (state_q == AW_W) || (state_q == WAIT_AW);
  assign wvalid_o     = (state_q == AW_W) || (state_q == WAIT_W);
  assign bready_o     = (state_q == B);
  assign hs_ready_o   = (state_q == ACK);
  assign hs_err_o     = hs_ready_o && (code_q != RESP_OKAY);
  assign hs_errcode_o = code_q;
  assign hs_data_o    = rdata_q;

  assign araddr_o = arvalid_o ? addr_q  : '0;
  assign awaddr_o = awvalid_o ? addr_q  : '0;
  assign wdata_o  = wvalid_o  ? wdata_q : '0;
  assign wstrb_o  = wvalid_o  ? strb_q  : '0;

endmodule

// File: tb/tb_axil_master_gen.sv
// Scoreboard bench for axil_master_gen with a delay-programmable AXI-Lite slave.
module tb_axil_master_gen;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int SW    = DW / 8;
  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic          clk, rst_i;
  logic          hs_read_i, hs_write_i;
  logic [AW-1:0] hs_addr_i;
  logic [DW-1:0] hs_data_i;
  logic [SW-1:0] byte_select_i;
  logic          hs_ready_o, hs_err_o;
  logic [DW-1:0] hs_data_o;
  logic [1:0]    hs_errcode_o;
  logic          arvalid_o, arready_i;
  logic [AW-1:0] araddr_o;
  logic          rvalid_i, rready_o;
  logic [DW-1:0] rdata_i;
  logic [1:0]    rresp_i;
  logic          awvalid_o, awready_i;
  logic [AW-1:0] awaddr_o;
  logic          wvalid_o, wready_i;
  logic [DW-1:0] wdata_o;
  logic [SW-1:0] wstrb_o;
  logic          bvalid_i, bready_o;
  logic [1:0]    bresp_i;

  axil_master_gen #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .hs_read_i(hs_read_i), .hs_write_i(hs_write_i), .hs_addr_i(hs_addr_i),
    .hs_data_i(hs_data_i), .byte_select_i(byte_select_i),
    .hs_ready_o(hs_ready_o), .hs_data_o(hs_data_o), .hs_err_o(hs_err_o),
    .hs_errcode_o(hs_errcode_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          err;
    logic [1:0]    code;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            errors = 0;
  int            checks = 0;

  int            ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [DW-1:0] cfg_rdata;
  logic [1:0]    cfg_rresp, cfg_bresp;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_wstrb;
  logic [DW-1:0] model_rdata;
  int            ar_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: each ready/valid fires a programmed number of cycles after the master starts waiting.
  int ar_c, r_c, aw_c, w_c, b_c;
  initial begin
    arready_i = 0; rvalid_i = 0; rdata_i = '0; rresp_i = '0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = '0;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    forever begin
      @(negedge clk);
      if (arvalid_o) begin arready_i = (ar_c == ar_dly); ar_c++; end
      else begin arready_i = 0; ar_c = 0; end
      if (awvalid_o) begin awready_i = (aw_c == aw_dly); aw_c++; end
      else begin awready_i = 0; aw_c = 0; end
      if (wvalid_o) begin wready_i = (w_c == w_dly); w_c++; end
      else begin wready_i = 0; w_c = 0; end
      if (rready_o) begin
        rvalid_i = (r_c == r_dly);
        rdata_i  = rvalid_i ? cfg_rdata : '0;
        rresp_i  = rvalid_i ? cfg_rresp : 2'b00;
        r_c++;
      end else begin
        rvalid_i = 0; rdata_i = '0; rresp_i = 2'b00; r_c = 0;
      end
      if (bready_o) begin
        bvalid_i = (b_c == b_dly);
        bresp_i  = bvalid_i ? cfg_bresp : 2'b00;
        b_c++;
      end else begin
        bvalid_i = 0; bresp_i = 2'b00; b_c = 0;
      end
    end
  end

  // Monitor: AXI-side payload checks plus scoreboard pops on each completion pulse.
  bit ar_done, aw_done, w_done, prev_rdy;
  initial begin
    ar_done = 0; aw_done = 0; w_done = 0; prev_rdy = 0; ar_cycles = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!arvalid_o) check("araddr_zero", 64'(araddr_o), 64'd0);
      if (!awvalid_o) check("awaddr_zero", 64'(awaddr_o), 64'd0);
      if (!wvalid_o) begin
        check("wdata_zero", wdata_o, 64'd0);
        check("wstrb_zero", 64'(wstrb_o), 64'd0);
      end
      if (arvalid_o) ar_cycles++;
      if (ar_done) check("arvalid_reassert", 64'(arvalid_o), 64'd0);
      else if (arvalid_o && arready_i) begin
        check("araddr", 64'(araddr_o), 64'(exp_addr));
        ar_done = 1;
      end
      if (aw_done) check("awvalid_reassert", 64'(awvalid_o), 64'd0);
      else if (awvalid_o && awready_i) begin
        check("awaddr", 64'(awaddr_o), 64'(exp_addr));
        aw_done = 1;
      end
      if (w_done) check("wvalid_reassert", 64'(wvalid_o), 64'd0);
      else if (wvalid_o && wready_i) begin
        check("wdata", wdata_o, exp_wdata);
        check("wstrb", 64'(wstrb_o), 64'(exp_wstrb));
        w_done = 1;
      end
      if (prev_rdy) check("ready_one_cycle", 64'(hs_ready_o), 64'd0);
      if (!hs_ready_o) check("err_without_ready", 64'(hs_err_o), 64'd0);
      if (hs_ready_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got a completion pulse, expected none at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("hs_err", 64'(hs_err_o), 64'(mon_e.err));
          check("hs_errcode", 64'(hs_errcode_o), 64'(mon_e.code));
          check("hs_data", hs_data_o, mon_e.data);
        end
      end
      if (hs_ready_o || !rst_i) begin
        ar_done = 0; aw_done = 0; w_done = 0;
      end
      prev_rdy = hs_ready_o;
    end
  end

  task automatic set_slave(input int ar, input int r, input int aw, input int w, input int b,
                           input logic [DW-1:0] rd, input logic [1:0] rr, input logic [1:0] br);
    ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    cfg_rdata = rd; cfg_rresp = rr; cfg_bresp = br;
  endtask

  // Reference: a phase times out if the slave needs TIMEOUT or more cycles after it begins.
  function automatic exp_t predict(input bit rd);
    exp_t e;
    bit   to;
    int   lo, hi;
    if (rd) begin
      to = (ar_dly >= TO) || (r_dly >= TO);
    end else begin
      lo = (aw_dly < w_dly) ? aw_dly : w_dly;
      hi = (aw_dly < w_dly) ? w_dly : aw_dly;
      to = (lo >= TO) || ((hi - lo - 1) >= TO) || (b_dly >= TO);
    end
    if (to) begin
      e.code = 2'b01;
    end else if (rd) begin
      e.code = cfg_rresp;
      model_rdata = cfg_rdata;
    end else begin
      e.code = cfg_bresp;
    end
    e.err  = (e.code != 2'b00);
    e.data = model_rdata;
    return e;
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (!hs_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!hs_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no completion pulse, expected one within 200 cycles");
    end
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb,
                         input bit poke_ack, output int n);
    exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
    sb_q.push_back(predict(rd));
    @(negedge clk);
    ar_cycles = 0;
    hs_read_i = rd; hs_write_i = wr; hs_addr_i = addr; hs_data_i = data; byte_select_i = strb;
    @(negedge clk);
    hs_read_i = 0; hs_write_i = 0;
    hs_addr_i = $urandom; hs_data_i = {$urandom, $urandom}; byte_select_i = SW'($urandom);
    wait_ready(n);
    if (poke_ack) begin
      hs_write_i = 1;
      @(negedge clk);
      hs_write_i = 0;
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected one before 200000 time units");
    $fatal(1, "watchdog");
  end

  int n;
  initial begin
    rst_i = 0; hs_read_i = 0; hs_write_i = 0; hs_addr_i = '0; hs_data_i = '0; byte_select_i = '0;
    model_rdata = '0;
    set_slave(0, 0, 0, 0, 0, '0, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    check("rst_hs_ready", 64'(hs_ready_o), 64'd0);
    check("rst_hs_data", hs_data_o, 64'd0);
    check("rst_errcode", 64'(hs_errcode_o), 64'd0);
    check("rst_valids", 64'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}), 64'd0);
    rst_i = 1;
    repeat (2) @(negedge clk);

    set_slave(2, 0, 0, 0, 0, 64'hDEAD_BEEF, 2'b00, 2'b00);
    run_txn(1, 0, 32'h0000_1000, '0, '0, 0, n);
    set_slave(0, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 2'b00);
    run_txn(1, 0, 32'h0000_1008, '0, '0, 0, n);
    check("read_latency", 64'(n), 64'd2);
    set_slave(0, 0, 2, 0, 0, '0, 2'b00, 2'b00);
    run_txn(0, 1, 32'h0000_2000, 64'h1234_5678, 8'h0F, 0, n);
    set_slave(0, 0, 1, 1, 3, '0, 2'b00, 2'b10);
    run_txn(0, 1, 32'h0000_2004, 64'hCAFE_F00D, 8'hFF, 1, n);
    set_slave(0, 0, 0, 4, 1, '0, 2'b00, 2'b00);
    run_txn(0, 1, 32'h0000_3000, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 0, n);

    set_slave(NEVER, 0, 0, 0, 0, 64'h1111, 2'b00, 2'b00);
    run_txn(1, 0, 32'h0000_4000, '0, '0, 0, n);
    check("ar_timeout_cycles", 64'(ar_cycles), 64'(TO));
    set_slave(0, NEVER, 0, 0, 0, 64'h2222, 2'b00, 2'b00);
    run_txn(1, 0, 32'h0000_4004, '0, '0, 0, n);
    set_slave(0, 0, 0, NEVER, 0, '0, 2'b00, 2'b00);
    run_txn(0, 1, 32'h0000_4008, 64'h3333, 8'h3C, 0, n);
    set_slave(0, 0, 0, 0, NEVER, '0, 2'b00, 2'b00);
    run_txn(0, 1, 32'h0000_400C, 64'h4444, 8'hC3, 0, n);
    set_slave(1, 2, 0, 0, 0, 64'hBAD0_BAD0, 2'b11, 2'b00);
    run_txn(1, 0, 32'h0000_5000, '0, '0, 0, n);

    // Simultaneous read and write, then reset while waiting in R.
    set_slave(0, NEVER, 0, 0, 0, '0, 2'b00, 2'b00);
    exp_addr = 32'h0000_6000;
    @(negedge clk);
    hs_read_i = 1; hs_write_i = 1; hs_addr_i = 32'h0000_6000; hs_data_i = 64'h77; byte_select_i = 8'hFF;
    @(negedge clk);
    hs_read_i = 0; hs_write_i = 0;
    n = 0;
    while (!rready_o && n < 20) begin
      check("no_aw_on_dual_req", 64'(awvalid_o), 64'd0);
      @(negedge clk);
      n++;
    end
    check("dual_req_reaches_r", 64'(rready_o), 64'd1);
    #3;
    rst_i = 0;
    #1;
    check("midrst_valids", 64'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}), 64'd0);
    check("midrst_ready_err", 64'({hs_ready_o, hs_err_o}), 64'd0);
    check("midrst_data", hs_data_o, 64'd0);
    check("midrst_errcode", 64'(hs_errcode_o), 64'd0);
    @(negedge clk);
    #3;
    rst_i = 1;
    model_rdata = '0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      set_slave($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                $urandom_range(0, 6), $urandom_range(0, 6), {$urandom, $urandom},
                2'($urandom), 2'($urandom));
      run_txn($urandom_range(0, 1) == 1, 1, $urandom, {$urandom, $urandom}, SW'($urandom), 0, n);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
